// File: rtl/bench_bist_pkg.sv
// Shared types and helpers for the bench8 BIST controller.
// Latency: n/a (package: state enum, Galois polynomial, step function, delay limit).
// Backpressure: n/a.
package bench_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Feedback taps of x^8+x^4+x^3+x^2+1 (x^8 term implicit).
  localparam logic [7:0] BIST_POLY = 8'h1D;

  // Largest response latency the 3-bit delay counter can track.
  localparam int unsigned MAX_CAPTURE_DELAY = 7;

  // One Galois shift: multiply by x modulo the polynomial.
  function automatic logic [7:0] galois_step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? BIST_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bist_galois8.sv
// 8-bit Galois shift register with parallel load and data-XOR input (LFSR or MISR).
// Latency: 1 cycle from load_i/en_i to q_o.
// Backpressure: none; en_i=0 simply holds the register.
// Ports: clk_i/rst_i (async active-high), load_i+load_val_i (load wins over en_i),
//        en_i (advance one step), data_i (XORed into the step; tie 0 for an LFSR), q_o.
module bist_galois8
  import bench_bist_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = galois_step(q_q) ^ data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bench8_bist.sv
// BIST controller: drives vectors onto an 8-in/8-out core and compacts its responses in a MISR.
// Latency: done pulses the cycle after edge E0+NUM_PATTERNS+CAPTURE_DELAY (E0 = start edge).
// Backpressure: none; start is ignored while busy, abort cancels a run immediately.
// Ports: clk, rst (async active-high), start, abort, dut_pi (stimulus), dut_po (response),
//        busy, done, pass, signature.
// Build option: define BIST_EXHAUSTIVE_EN for a binary up-counter source (00..FF) instead of the LFSR.
module bench8_bist
  import bench_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS  = 256,
  parameter logic [7:0]  LFSR_SEED     = 8'h01,
  parameter int unsigned CAPTURE_DELAY = 0,
  parameter logic [7:0]  GOLDEN_SIG    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] dut_pi,
  input  logic [7:0] dut_po,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam int unsigned DLY_C      = (CAPTURE_DELAY > MAX_CAPTURE_DELAY) ? MAX_CAPTURE_DELAY
                                                                           : CAPTURE_DELAY;
  localparam logic [8:0]  LAST_IDX   = 9'(NUM_PATTERNS - 1);
  localparam logic [8:0]  DLY9       = 9'(DLY_C);
  localparam logic [2:0]  FLUSH_LAST = (DLY_C == 0) ? 3'd0 : 3'(DLY_C - 1);

  bist_state_e state_q;
  logic [8:0]  pat_cnt_q;   // edges since the start edge, minus one; index of vector on dut_pi while < LAST_IDX
  logic [2:0]  dly_cnt_q;   // cycles spent in FLUSH
  logic        busy_q, done_q, pass_q;

  logic active, start_ok, vec_adv, cap_en;
  logic [7:0] sig_nxt;

  assign active   = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign start_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign vec_adv  = (state_q == ST_RUN) && !abort && (pat_cnt_q < LAST_IDX);
  // The response to vector k is valid DLY_C edges after it was driven, so
  // capturing only once pat_cnt reaches DLY_C gives exactly N captures, even when N < DLY_C.
  assign cap_en   = active && !abort && (pat_cnt_q >= DLY9);
  // Signature value after this edge, used to register pass on DONE entry.
  assign sig_nxt  = cap_en ? (galois_step(signature) ^ dut_po) : signature;

`ifdef BIST_EXHAUSTIVE_EN
  logic [7:0] vec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= 8'h00;
    end else if (start_ok) begin
      vec_q <= 8'h00;
    end else if (vec_adv) begin
      vec_q <= vec_q + 8'd1;
    end
  end

  assign dut_pi = vec_q;
`else
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  bist_galois8 u_lfsr (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (start_ok),
    .load_val_i (SEED),
    .en_i       (vec_adv),
    .data_i     (8'h00),
    .q_o        (dut_pi)
  );
`endif

  bist_galois8 u_misr (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (start_ok),
    .load_val_i (8'h00),
    .en_i       (cap_en),
    .data_i     (dut_po),
    .q_o        (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_cnt_q <= 9'd0;
      dly_cnt_q <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            pat_cnt_q <= 9'd0;
            dly_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        ST_RUN, ST_FLUSH: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            pat_cnt_q <= pat_cnt_q + 9'd1;
            if (state_q == ST_RUN) begin
              if (pat_cnt_q == LAST_IDX) begin
                if (DLY_C == 0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (sig_nxt == GOLDEN_SIG);
                end else begin
                  state_q   <= ST_FLUSH;
                  dly_cnt_q <= 3'd0;
                end
              end
            end else begin
              dly_cnt_q <= dly_cnt_q + 3'd1;
              if (dly_cnt_q == FLUSH_LAST) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (sig_nxt == GOLDEN_SIG);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_bench8_bist.sv
// Directed bench for bench8_bist: loopback, tied-zero, capture-delay, abort and async reset cases.
// Three instances share clk/rst: a (N=3, delay 0), b (N=256, delay 0), c (N=3, delay 2).
// Expected vectors/signatures are hand-derived; the exhaustive build swaps in its own table.
module tb_bench8_bist;

`ifdef BIST_EXHAUSTIVE_EN
  localparam logic [7:0] V0 = 8'h00, V1 = 8'h01, V2 = 8'h02, V255 = 8'hFF;
  localparam logic [7:0] S1 = 8'h00, S2 = 8'h01, S3 = 8'h00;
  localparam logic       PASS_A = 1'b0;
`else
  localparam logic [7:0] V0 = 8'h01, V1 = 8'h02, V2 = 8'h04, V255 = 8'h01;
  localparam logic [7:0] S1 = 8'h01, S2 = 8'h00, S3 = 8'h04;
  localparam logic       PASS_A = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_abort = 1'b0, a_busy, a_done, a_pass;
  logic [7:0] a_pi, a_po, a_sig;
  logic       b_start = 1'b0, b_abort = 1'b0, b_busy, b_done, b_pass;
  logic [7:0] b_pi, b_sig;
  logic [7:0] b_po = 8'h00;
  logic       c_start = 1'b0, c_abort = 1'b0, c_busy, c_done, c_pass;
  logic [7:0] c_pi, c_po, c_sig, c_p1, c_p2;

  assign a_po = a_pi;

  // Two-stage pipelined loopback core for the delayed-capture instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_p1 <= 8'h00;
      c_p2 <= 8'h00;
    end else begin
      c_p1 <= c_pi;
      c_p2 <= c_p1;
    end
  end
  assign c_po = c_p2;

  bench8_bist #(.NUM_PATTERNS(3), .LFSR_SEED(8'h01), .CAPTURE_DELAY(0), .GOLDEN_SIG(8'h04)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .dut_pi(a_pi), .dut_po(a_po),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

  bench8_bist #(.NUM_PATTERNS(256), .LFSR_SEED(8'h01), .CAPTURE_DELAY(0), .GOLDEN_SIG(8'h00)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .dut_pi(b_pi), .dut_po(b_po),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

  bench8_bist #(.NUM_PATTERNS(3), .LFSR_SEED(8'h01), .CAPTURE_DELAY(2), .GOLDEN_SIG(8'h04)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .dut_pi(c_pi), .dut_po(c_po),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig));

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] nextv(input logic [7:0] v);
`ifdef BIST_EXHAUSTIVE_EN
    return v + 8'd1;
`else
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
`endif
  endfunction

  initial begin
    logic [7:0] v;
    int errs, done_at, busy_cnt, n_done;

    repeat (2) tick;
    rst = 1'b0;
    tick;
    check("rst_pi",   16'(a_pi),   16'h0);
    check("rst_busy", 16'(a_busy), 16'h0);
    check("rst_done", 16'(a_done), 16'h0);
    check("rst_pass", 16'(a_pass), 16'h0);
    check("rst_sig",  16'(a_sig),  16'h0);

    // Loopback, N=3.
    a_start = 1'b1; tick; a_start = 1'b0;
    check("lb_pi0",   16'(a_pi),   16'(V0));
    check("lb_busy",  16'(a_busy), 16'h1);
    check("lb_sig0",  16'(a_sig),  16'h0);
    tick;
    check("lb_pi1",   16'(a_pi),   16'(V1));
    check("lb_sig1",  16'(a_sig),  16'(S1));
    tick;
    check("lb_pi2",   16'(a_pi),   16'(V2));
    check("lb_sig2",  16'(a_sig),  16'(S2));
    check("lb_nodone", 16'(a_done), 16'h0);
    tick;
    check("lb_hold",  16'(a_pi),   16'(V2));
    check("lb_sig3",  16'(a_sig),  16'(S3));
    check("lb_done",  16'(a_done), 16'h1);
    check("lb_pass",  16'(a_pass), 16'(PASS_A));
    check("lb_busy_fall", 16'(a_busy), 16'h0);

    // Start during the done cycle is accepted.
    a_start = 1'b1; tick; a_start = 1'b0;
    check("b2b_busy", 16'(a_busy), 16'h1);
    check("b2b_pi",   16'(a_pi),   16'(V0));
    check("b2b_sig",  16'(a_sig),  16'h0);
    check("b2b_pass", 16'(a_pass), 16'h0);
    repeat (3) tick;
    check("b2b_done", 16'(a_done), 16'h1);
    tick;
    check("done_pulse", 16'(a_done), 16'h0);
    check("pass_hold",  16'(a_pass), 16'(PASS_A));

    // Tied-zero response, N=256.
    b_start = 1'b1; tick; b_start = 1'b0;
    v = V0; errs = 0; done_at = 0;
    if (b_pi !== v) errs++;
    for (int k = 1; k <= 400 && done_at == 0; k++) begin
      tick;
      if (k <= 255) begin
        v = nextv(v);
        if (b_pi !== v) errs++;
      end
      if (b_done) done_at = k;
    end
    check("tz_vec_seq",   16'(errs),    16'd0);
    check("tz_done_edge", 16'(done_at), 16'd256);
    check("tz_last_vec",  16'(b_pi),    16'(V255));
    check("tz_sig",       16'(b_sig),   16'h0);
    check("tz_pass",      16'(b_pass),  16'h1);

    // Capture delay 2 with a two-stage pipelined core.
    c_start = 1'b1; tick; c_start = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick;
      if (c_busy) busy_cnt++;
      if (c_done && done_at == 0) done_at = k;
      if (k == 2) check("cd_sig_e2", 16'(c_sig), 16'h0);
      if (k == 3) check("cd_sig_e3", 16'(c_sig), 16'(S1));
      if (k == 4) check("cd_sig_e4", 16'(c_sig), 16'(S2));
    end
    check("cd_busy_cycles", 16'(busy_cnt), 16'd5);
    check("cd_done_edge",   16'(done_at),  16'd5);
    check("cd_sig",         16'(c_sig),    16'(S3));
    check("cd_pass",        16'(c_pass),   16'(PASS_A));

    // Abort at cycle 10, with start also asserted: abort wins.
    b_start = 1'b1; tick; b_start = 1'b0;
    repeat (9) tick;
    check("ab_pre_busy", 16'(b_busy), 16'h1);
    b_abort = 1'b1; b_start = 1'b1; tick; b_abort = 1'b0; b_start = 1'b0;
    check("ab_busy", 16'(b_busy), 16'h0);
    check("ab_done", 16'(b_done), 16'h0);
    check("ab_pass", 16'(b_pass), 16'h0);
    n_done = 0;
    for (int k = 0; k < 300; k++) begin
      tick;
      if (b_done || b_busy) n_done++;
    end
    check("ab_stays_idle", 16'(n_done), 16'd0);
    b_start = 1'b1; tick; b_start = 1'b0;
    check("ab_restart_pi",   16'(b_pi),   16'(V0));
    check("ab_restart_sig",  16'(b_sig),  16'h0);
    check("ab_restart_busy", 16'(b_busy), 16'h1);

    // Asynchronous reset mid-cycle during a run.
    repeat (5) tick;
    check("rm_pre_pi", 16'(b_pi == 8'h00), 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rm_pi",   16'(b_pi),   16'h0);
    check("rm_busy", 16'(b_busy), 16'h0);
    check("rm_sig",  16'(b_sig),  16'h0);
    check("rm_pass_a", 16'(a_pass), 16'h0);
    b_start = 1'b1;
    tick; tick;
    check("rm_start_ign", 16'(b_busy), 16'h0);
    b_start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    check("rm_after_busy", 16'(b_busy), 16'h0);
    check("rm_after_done", 16'(b_done), 16'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
